// File: rtl/shift_reg_deser.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_deser
// Purpose  : Parametrised universal shift register with word framing.
//            Supports hold, shift right, shift left and parallel load. A
//            shift counter frames the serial stream into WIDTH-bit words.
//            Each completed word is captured into a holding register, and a
//            one-cycle valid strobe accompanies the capture.
// Ports    : clk        - clock, rising edge
//            clr        - synchronous active-high reset
//            mode       - 00 hold, 01 shift right, 10 shift left, 11 load
//            din        - serial data in
//            pdin       - parallel load data
//            q          - live shift register contents
//            sout       - bit shifted out at the most recent shift edge
//            dout       - last complete captured word
//            word_valid - one-cycle pulse, dout updated this cycle
//            bit_cnt    - shifts accumulated in the current word
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_deser #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             din,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [WIDTH-1:0] dout,
    output logic             word_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [1:0]       c_hold  = 2'b00;
    localparam logic [1:0]       c_shr   = 2'b01;
    localparam logic [1:0]       c_shl   = 2'b10;
    localparam logic [1:0]       c_load  = 2'b11;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_q_shift;
    logic             w_sout_shift;

    // Post-shift register value; also the word captured on the final shift,
    // so dout lines up with q on the same edge.
    always_comb begin
        w_q_shift    = r_q;
        w_sout_shift = r_sout;
        case (mode)
            c_shr: begin
                w_q_shift    = {din, r_q[WIDTH-1:1]};
                w_sout_shift = r_q[0];
            end
            c_shl: begin
                w_q_shift    = {r_q[WIDTH-2:0], din};
                w_sout_shift = r_q[WIDTH-1];
            end
            default: begin
                w_q_shift    = r_q;
                w_sout_shift = r_sout;
            end
        endcase
    end

    assign w_shift = (mode == c_shr) || (mode == c_shl);
    assign w_last  = w_shift && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // The strobe is only raised on a word-completing edge.
            r_valid <= 1'b0;
            case (mode)
                c_hold: begin
                    r_q <= r_q;
                end
                c_load: begin
                    r_q   <= pdin;
                    r_cnt <= '0;
                end
                default: begin
                    r_q    <= w_q_shift;
                    r_sout <= w_sout_shift;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_dout  <= w_q_shift;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign q          = r_q;
    assign sout       = r_sout;
    assign dout       = r_dout;
    assign word_valid = r_valid;
    assign bit_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_deser
// Purpose  : Self-checking bench for shift_reg_deser at WIDTH=4. Directed
//            vector table followed by randomized stimulus against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_deser;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             clr;
    logic [1:0]       mode;
    logic             din;
    logic [WIDTH-1:0] pdin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [WIDTH-1:0] dout;
    logic             word_valid;
    logic [CNT_W-1:0] bit_cnt;

    int n_vec = 0;
    int n_err = 0;

    shift_reg_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .mode       (mode),
        .din        (din),
        .pdin       (pdin),
        .q          (q),
        .sout       (sout),
        .dout       (dout),
        .word_valid (word_valid),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c;
        logic [1:0] m;
        logic       d;
        logic [3:0] p;
        logic [3:0] eq;
        logic       es;
        logic [3:0] ed;
        logic       ev;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic [1:0] m, input logic d,
                                input logic [3:0] p, input logic [3:0] eq, input logic es,
                                input logic [3:0] ed, input logic ev, input logic [1:0] ec);
        vec_t v;
        v.c = c; v.m = m; v.d = d; v.p = p;
        v.eq = eq; v.es = es; v.ed = ed; v.ev = ev; v.ec = ec;
        return v;
    endfunction

    task automatic step(input logic c, input logic [1:0] m, input logic d, input logic [3:0] p);
        clr  = c;
        mode = m;
        din  = d;
        pdin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {q, sout, dout, word_valid, bit_cnt};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got q=%b sout=%b dout=%b valid=%b cnt=%0d, want q=%b sout=%b dout=%b valid=%b cnt=%0d",
                     name, got[11:8], got[7], got[6:3], got[2], got[1:0],
                     exp[11:8], exp[7], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    // Behavioural reference: integers and modulo arithmetic.
    int m_q, m_sout, m_dout, m_valid, m_cnt, m_since;

    task automatic model(input logic c, input logic [1:0] m, input logic d, input logic [3:0] p);
        if (c) begin
            m_q = 0; m_sout = 0; m_dout = 0; m_valid = 0; m_cnt = 0;
        end else if (m == 2'd0) begin
            m_valid = 0;
        end else if (m == 2'd3) begin
            m_q = int'(p); m_cnt = 0; m_valid = 0;
        end else begin
            if (m == 2'd1) begin
                m_sout = m_q % 2;
                m_q    = (int'(d) * (1 << (WIDTH - 1))) + (m_q / 2);
            end else begin
                m_sout = (m_q / (1 << (WIDTH - 1))) % 2;
                m_q    = (m_q * 2 + int'(d)) % (1 << WIDTH);
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == WIDTH) begin
                m_cnt = 0; m_dout = m_q; m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        clr = 1'b0; mode = 2'b00; din = 1'b0; pdin = '0;
        // 1. reset
        vecs.push_back(mk(1, 2'b01, 1, 4'hF, 4'b0000, 0, 4'b0000, 0, 2'd0));
        // 2. shift right 1,1,0,1
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1000, 0, 4'b0000, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0110, 0, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1011, 0, 4'b1011, 1, 2'd0));
        // 3. load 1010, shift left din=0
        vecs.push_back(mk(0, 2'b11, 1, 4'b1010, 4'b1010, 0, 4'b1011, 0, 2'd0));
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b0100, 1, 4'b1011, 0, 2'd1));
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b1000, 0, 4'b1011, 0, 2'd2));
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b0000, 1, 4'b1011, 0, 2'd3));
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b0000, 0, 4'b0000, 1, 2'd0));
        // 4. two shifts, three holds, two shifts
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1000, 0, 4'b0000, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b00, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b00, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b00, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1110, 0, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 0, 4'b1111, 1, 2'd0));
        // 5. three shifts, clr mid-word, four fresh shifts
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 1, 4'b1111, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 1, 4'b1111, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 1, 4'b1111, 0, 2'd3));
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b0000, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1000, 0, 4'b0000, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1100, 0, 4'b0000, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1110, 0, 4'b0000, 0, 2'd3));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 0, 4'b1111, 1, 2'd0));
        // 6. eight continuous shifts 1,0,0,0,0,1,1,1
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1111, 1, 4'b1111, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0111, 1, 4'b1111, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0011, 1, 4'b1111, 0, 2'd3));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0001, 1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0000, 1, 4'b0001, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1000, 0, 4'b0001, 0, 2'd2));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1100, 0, 4'b0001, 0, 2'd3));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1110, 0, 4'b1110, 1, 2'd0));
        // load mid-word discards the partial count; loaded + shifted bits form the word
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b1100, 1, 4'b1110, 0, 2'd1));
        vecs.push_back(mk(0, 2'b11, 0, 4'b0101, 4'b0101, 1, 4'b1110, 0, 2'd0));
        vecs.push_back(mk(0, 2'b10, 1, 4'h0, 4'b1011, 0, 4'b1110, 0, 2'd1));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0101, 1, 4'b1110, 0, 2'd2));
        vecs.push_back(mk(0, 2'b10, 0, 4'h0, 4'b1010, 0, 4'b1110, 0, 2'd3));
        vecs.push_back(mk(0, 2'b10, 1, 4'h0, 4'b0101, 1, 4'b0101, 1, 2'd0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].m, vecs[i].d, vecs[i].p);
            check($sformatf("vec%0d", i),
                  {vecs[i].eq, vecs[i].es, vecs[i].ed, vecs[i].ev, vecs[i].ec});
        end

        // Back-to-back words: continuous shifting pulses exactly WIDTH apart.
        step(1'b1, 2'b00, 1'b0, 4'h0);
        m_since = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            step(1'b0, 2'b01, 1'(i % 3 == 0), 4'h0);
            m_since++;
            n_vec++;
            if (word_valid !== ((m_since % WIDTH) == 0)) begin
                n_err++;
                $display("FAIL b2b_pulse%0d: got valid=%b want %b", i, word_valid,
                         ((m_since % WIDTH) == 0));
            end
        end

        // Randomized phase against the behavioural model.
        step(1'b1, 2'b00, 1'b0, 4'h0);
        model(1'b1, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 600; i++) begin
            logic       rc;
            logic [1:0] rm;
            logic       rd;
            logic [3:0] rp;
            int         sel;
            rc  = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 9);
            rm  = (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : (sel < 9) ? 2'b00 : 2'b11;
            rd  = 1'($urandom_range(0, 1));
            rp  = 4'($urandom_range(0, 15));
            step(rc, rm, rd, rp);
            model(rc, rm, rd, rp);
            check($sformatf("rand%0d", i),
                  {4'(m_q), 1'(m_sout), 4'(m_dout), 1'(m_valid), 2'(m_cnt)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_reg_deser.md
Name: shift_reg_deser

Overview:
- Parametrised universal shift register with word framing; successor to the team's fixed 4-bit serial-in/parallel-out register.
- Adds configurable width, four modes (hold, shift right, shift left, parallel load), a serial output and a shift counter.
- The counter captures each complete serial word into a holding register with a one-cycle valid strobe.
- Sits between a serial link front-end and word-oriented datapath logic.

Parameters:
- WIDTH, 8, register/word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH) (min 1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- din  input  1  serial data in.
- pdin  input  WIDTH  parallel load data.
- q  output  WIDTH  live shift register contents (registered).
- sout  output  1  bit shifted out at the most recent shift edge (registered).
- dout  output  WIDTH  last complete captured word (registered).
- word_valid  output  1  one-cycle pulse: dout updated this cycle.
- bit_cnt  output  CNT_W  shifts accumulated in the current word (registered).

Behaviour:
- Reset (clr=1 at an edge): q=0, sout=0, dout=0, word_valid=0, bit_cnt=0.
- clr has priority over every mode; mode and din are ignored that cycle.
- mode 00: q, sout, bit_cnt and dout hold; word_valid=0.
- mode 01: q <= {din, q[WIDTH-1:1]}; sout <= old q[0].
- mode 10: q <= {q[WIDTH-2:0], din}; sout <= old q[WIDTH-1].
- mode 11: q <= pdin; bit_cnt <= 0; sout holds; word_valid=0; dout holds.
- Counting: every shift edge (01 or 10) increments bit_cnt. Direction changes mid-word do not reset the count.
- Word completion: on the shift edge where bit_cnt == WIDTH-1:
  - bit_cnt wraps to 0;
  - dout <= the new q value (post-shift, same edge);
  - word_valid=1 for exactly that following cycle.
- Latency: dout and word_valid appear one edge after the final bit is presented on din, aligned with q showing the same word.
- word_valid is deasserted on every edge that does not complete a word, including hold, load and clr edges.
- Back-to-back words: continuous shifting gives word_valid pulses exactly WIDTH cycles apart, with no dead cycle.
- Reset mid-word: the partial word is discarded; no valid pulse; the next word needs WIDTH fresh shifts.
- Load mid-word: the partial count is discarded. Shifting after a load counts from 0, so loaded bits plus shifted-in bits form the next captured word.
- Wrap-around: bit_cnt wraps modulo WIDTH only; for non-power-of-2 WIDTH it never reaches WIDTH.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=4):
1. clr=1 for one edge from unknown state -> q=0000, dout=0000, sout=0, bit_cnt=0, word_valid=0.
2. mode=01, din=1,1,0,1 on four edges:
   - q=1000, 1100, 0110, 1011;
   - bit_cnt=1, 2, 3, 0;
   - word_valid=1 only after the 4th edge, with dout=1011.
3. mode=11, pdin=1010, then mode=10 with din=0 for four edges:
   - q=0100, 1000, 0000, 0000;
   - sout=1, 0, 1, 0;
   - word_valid after the 4th shift with dout=0000.
4. mode=01 two shifts, mode=00 three cycles, mode=01 two shifts (din=1 throughout):
   - q frozen at 1100 during hold;
   - bit_cnt holds at 2;
   - single word_valid after the 4th shift with dout=1111.
5. Three shifts, then clr=1 with mode=01 -> q=0000, bit_cnt=0, no word_valid. The next valid pulse appears only after 4 further shifts.
6. Eight continuous mode=01 shifts, din=1,0,0,0,0,1,1,1:
   - word_valid after edges 4 and 8 only;
   - dout=0001 then 1110.
